math_divider_seq: RTL and testbench

//  Sequential unsigned attempt-subtraction divider: one quotient bit per clock.
//  One internal row of N+1 controlled-subtract cells per iteration (d=a-b-bi; os selects a or d).

---
 rtl/math_divider_seq.sv | 132 +++++++++++++
 tb/tb_math_divider_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/math_divider_seq.sv
// Sequential restoring divider: one row of N+1 controlled-subtract cells is reused
// for N iterations, yielding one quotient bit per clock behind a start/ready/done handshake.

module math_divider_seq_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bi_i,
    input  logic os_i,
    output logic bo_o,
    output logic r_o
);
    logic d;

    assign d    = a_i ^ b_i ^ bi_i;
    assign bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bi_i);
    assign r_o  = os_i ? a_i : d;
endmodule

module math_divider_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q;
    logic [N:0]    p_q;
    logic [N-1:0]  q_q, d_q;
    logic [CW-1:0] cnt_q;
    logic          done_q, dbz_q;
    logic [N-1:0]  quot_q, rem_q;

    logic [N:0]    t, dx, p_d;
    logic [N-1:0]  q_d;
    logic          bo_msb;

    assign t  = {p_q[N-1:0], q_q[N-1]};
    assign dx = {1'b0, d_q};

    // Borrow chain runs through per-cell nets; the row-wide restore select is
    // the borrow out of the top cell.
    for (genvar i = 0; i <= N; i++) begin : g_row
        logic bi, bo;
        if (i == 0) begin : g_lsb
            assign bi = 1'b0;
        end else begin : g_chain
            assign bi = g_row[i-1].bo;
        end
        math_divider_seq_cell u_cell (
            .a_i  (t[i]),
            .b_i  (dx[i]),
            .bi_i (bi),
            .os_i (bo_msb),
            .bo_o (bo),
            .r_o  (p_d[i])
        );
    end

    assign bo_msb = g_row[N].bo;
    assign q_d    = {q_q[N-2:0], ~bo_msb};

    // P[N] is zero at completion by construction; it stays in the register so
    // the partial remainder is visible at full row width.
    logic unused_p_msb;
    assign unused_p_msb = p_q[N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        quot_q  <= q_d;
                        rem_q   <= p_d[N-1:0];
                        dbz_q   <= 1'b0;
                    end
                end
                default: begin
                    if (start) begin
                        q_q   <= dividend;
                        d_q   <= divisor;
                        p_q   <= '0;
                        cnt_q <= '0;
                        if (divisor == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ready       = (state_q != S_RUN);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_math_divider_seq.sv
// Directed and model-based checks for math_divider_seq at N=8, plus an exhaustive N=4 sweep.

module tb_math_divider_seq;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0, divisor = '0;
    logic         ready, done, div_by_zero;
    logic [N-1:0] quotient, remainder;

    logic         start4 = 1'b0;
    logic [3:0]   dvd4 = '0, dvs4 = '0;
    logic         ready4, done4, dbz4;
    logic [3:0]   q4, r4;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    math_divider_seq #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    math_divider_seq #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividend(dvd4), .divisor(dvs4),
        .ready(ready4), .done(done4), .quotient(q4), .remainder(r4),
        .div_by_zero(dbz4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Acceptance edge is the posedge inside this task; returns at the negedge after it.
    task automatic accept(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, output int lat);
        lat = base;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_div(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] eq, input logic [7:0] er, input logic edbz);
        int lat;
        accept(a, b);
        if (b != 0) chk("ready_run", {31'd0, ready}, 32'd0);
        wait_done(0, lat);
        chk("latency", lat, (b == 0) ? 32'd0 : 32'd8);
        chk("quotient", {24'd0, quotient}, {24'd0, eq});
        chk("remainder", {24'd0, remainder}, {24'd0, er});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edbz});
        chk("p_msb_zero", {31'd0, dut.p_q[N]}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        logic seen;
        logic [7:0] a, b;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quot", {24'd0, quotient}, 32'd0);
        chk("rst_rem", {24'd0, remainder}, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        check_div(8'd200, 8'd7,   8'd28,  8'd4,   1'b0);
        check_div(8'd5,   8'd0,   8'hFF,  8'd5,   1'b1);
        check_div(8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
        check_div(8'd3,   8'd10,  8'd0,   8'd3,   1'b0);
        check_div(8'd255, 8'd255, 8'd1,   8'd0,   1'b0);
        check_div(8'd0,   8'd9,   8'd0,   8'd0,   1'b0);

        // start pulse mid-run must not disturb operands
        accept(8'd100, 8'd3);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, lat);
        chk("ign_latency", lat, 32'd8);
        chk("ign_quot", {24'd0, quotient}, 32'd33);
        chk("ign_rem", {24'd0, remainder}, 32'd1);
        @(negedge clk);

        // reset in the middle of a run
        accept(8'd100, 8'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rr_ready", {31'd0, ready}, 32'd1);
        chk("rr_done", {31'd0, done}, 32'd0);
        chk("rr_quot", {24'd0, quotient}, 32'd0);
        chk("rr_rem", {24'd0, remainder}, 32'd0);
        chk("rr_dbz", {31'd0, div_by_zero}, 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("rr_no_done", {31'd0, seen}, 32'd0);

        // back-to-back: start held in the done cycle
        accept(8'd200, 8'd7);
        wait_done(0, lat);
        chk("b2b_lat1", lat, 32'd8);
        chk("b2b_quot1", {24'd0, quotient}, 32'd28);
        start = 1'b1; dividend = 8'd17; divisor = 8'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_ready", {31'd0, ready}, 32'd0);
        chk("b2b_held", {24'd0, quotient}, 32'd28);
        wait_done(0, lat);
        chk("b2b_lat2", lat, 32'd8);
        chk("b2b_quot2", {24'd0, quotient}, 32'd4);
        chk("b2b_rem2", {24'd0, remainder}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (b == 0) check_div(a, b, 8'hFF, a, 1'b1);
            else        check_div(a, b, a / b, a % b, 1'b0);
        end

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                @(negedge clk);
                start4 = 1'b1; dvd4 = 4'(x); dvs4 = 4'(y);
                @(posedge clk);
                @(negedge clk);
                start4 = 1'b0;
                n = 0;
                while (done4 !== 1'b1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("n4_latency", n, (y == 0) ? 32'd0 : 32'd4);
                if (y == 0) chk("n4_result", {23'd0, dbz4, q4, r4}, {23'd0, 1'b1, 4'hF, 4'(x)});
                else        chk("n4_result", {23'd0, dbz4, q4, r4}, {23'd0, 1'b0, 4'(x / y), 4'(x % y)});
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
